// File: rtl/data_regfile_stage.sv
// Register file with write-back mux, optional same-edge bypass and zero register,
// feeding registered A/B operands and an extended immediate to the ALU.
module data_regfile_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned IMM_IN_W = 8,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          R0_ZERO  = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [ADDR_W-1:0]   input_reg_readA_address,
  input  logic [ADDR_W-1:0]   input_reg_readB_address,
  input  logic                input_reg_write,
  input  logic [ADDR_W-1:0]   input_reg_write_address,
  input  logic [1:0]          wb_sel,
  input  logic [DATA_W-1:0]   input_ALUOut,
  input  logic [DATA_W-1:0]   input_MDR,
  input  logic [DATA_W-1:0]   input_link,
  input  logic [IMM_IN_W-1:0] input_imm,
  input  logic                imm_signed,
  input  logic                input_branch,
  input  logic                hold,
  output logic [DATA_W-1:0]   output_reg_A,
  output logic [DATA_W-1:0]   output_reg_B,
  output logic [DATA_W-1:0]   output_imm
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [DATA_W-1:0] wdata;
  logic              wr_en;
  logic [DATA_W-1:0] imm_zx, imm_ext;

  always_comb begin
    wdata = input_ALUOut;
    unique case (wb_sel)
      2'b00:   wdata = input_ALUOut;
      2'b01:   wdata = input_MDR;
      2'b10:   wdata = input_link;
      default: wdata = '0;
    endcase
  end

  // Reserved select and writes to the hardwired zero register never commit.
  assign wr_en = input_reg_write && (wb_sel != 2'b11) &&
                 !(R0_ZERO && (input_reg_write_address == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[input_reg_write_address] = wdata;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (R0_ZERO && (addr == '0)) begin
      return '0;
    end else if (BYPASS && wr_en && (addr == input_reg_write_address)) begin
      return wdata;
    end else begin
      return regs_q[addr];
    end
  endfunction

  // Fill mask covers bits above the raw field; empty when widths match.
  always_comb begin
    imm_zx  = DATA_W'(input_imm);
    imm_ext = imm_zx;
    if (imm_signed && input_imm[IMM_IN_W-1]) begin
      imm_ext = imm_zx | ~((DATA_W'(1) << IMM_IN_W) - DATA_W'(1));
    end
    if (input_branch) begin
      imm_ext = imm_ext << 1;
    end
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    imm_d = imm_q;
    if (!hold) begin
      a_d   = read_port(input_reg_readA_address);
      b_d   = read_port(input_reg_readB_address);
      imm_d = imm_ext;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
    end else begin
      regs_q <= regs_d;
      a_q    <= a_d;
      b_q    <= b_d;
      imm_q  <= imm_d;
    end
  end

  assign output_reg_A = a_q;
  assign output_reg_B = b_q;
  assign output_imm   = imm_q;

endmodule

// File: tb/tb_data_regfile_stage.sv
// Directed bench: default configuration plus a BYPASS=0 copy sharing the same stimulus.
module tb_data_regfile_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  ra, rb, wa;
  logic        we;
  logic [1:0]  wb_sel;
  logic [15:0] alu, mdr, link;
  logic [7:0]  imm;
  logic        imm_signed, branch, hold;
  logic [15:0] a, b, imm_o;
  logic [15:0] a_nb, b_nb, imm_nb;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  data_regfile_stage u_dut (
    .CLK(CLK), .RST(RST),
    .input_reg_readA_address(ra), .input_reg_readB_address(rb),
    .input_reg_write(we), .input_reg_write_address(wa), .wb_sel(wb_sel),
    .input_ALUOut(alu), .input_MDR(mdr), .input_link(link),
    .input_imm(imm), .imm_signed(imm_signed), .input_branch(branch), .hold(hold),
    .output_reg_A(a), .output_reg_B(b), .output_imm(imm_o)
  );

  data_regfile_stage #(.BYPASS(1'b0)) u_dut_nb (
    .CLK(CLK), .RST(RST),
    .input_reg_readA_address(ra), .input_reg_readB_address(rb),
    .input_reg_write(we), .input_reg_write_address(wa), .wb_sel(wb_sel),
    .input_ALUOut(alu), .input_MDR(mdr), .input_link(link),
    .input_imm(imm), .imm_signed(imm_signed), .input_branch(branch), .hold(hold),
    .output_reg_A(a_nb), .output_reg_B(b_nb), .output_imm(imm_nb)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [1:0] sel, input logic [15:0] d);
    we = 1'b1; wa = addr; wb_sel = sel;
    alu = d; mdr = d; link = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    RST = 1'b1; ra = '0; rb = '0; wa = '0; we = 1'b0; wb_sel = 2'b00;
    alu = '0; mdr = '0; link = '0; imm = '0; imm_signed = 1'b0; branch = 1'b0;
    hold = 1'b0;
    step(); step();
    check("rst_a", a, 16'h0000);
    check("rst_b", b, 16'h0000);
    check("rst_imm", imm_o, 16'h0000);
    RST = 1'b0;

    // Write then read
    wr(3'd2, 2'b00, 16'hABCD);
    wr(3'd3, 2'b01, 16'h5678);
    ra = 3'd2; rb = 3'd3;
    step();
    check("rd_a", a, 16'hABCD);
    check("rd_b", b, 16'h5678);
    check("rd_b_nb", b_nb, 16'h5678);

    // Asynchronous reset with populated registers
    RST = 1'b1;
    #1;
    check("arst_a", a, 16'h0000);
    check("arst_b", b, 16'h0000);
    step();
    RST = 1'b0;
    step();
    check("post_rst_a", a, 16'h0000);
    check("post_rst_b", b, 16'h0000);

    // Bypass from link
    link = 16'h1234; we = 1'b1; wa = 3'd4; wb_sel = 2'b10; ra = 3'd4;
    step();
    we = 1'b0;
    check("byp_a", a, 16'h1234);
    check("nobyp_a", a_nb, 16'h0000);
    step();
    check("nobyp_a_next", a_nb, 16'h1234);

    // Zero register, both ports, under bypass
    ra = 3'd0; rb = 3'd0;
    wr(3'd0, 2'b00, 16'hFFFF);
    check("r0_a", a, 16'h0000);
    check("r0_b", b, 16'h0000);
    step();
    check("r0_a_after", a, 16'h0000);

    // Immediate modes
    imm = 8'h9C;
    imm_signed = 1'b1; branch = 1'b0; step(); check("imm_s", imm_o, 16'hFF9C);
    imm_signed = 1'b0; branch = 1'b0; step(); check("imm_u", imm_o, 16'h009C);
    imm_signed = 1'b1; branch = 1'b1; step(); check("imm_sb", imm_o, 16'hFF38);
    imm_signed = 1'b0; branch = 1'b1; step(); check("imm_ub", imm_o, 16'h0138);
    imm = 8'h05; imm_signed = 1'b1; branch = 1'b0; step(); check("imm_pos", imm_o, 16'h0005);

    // Hold while writing the held register
    ra = 3'd2; rb = 3'd4;
    wr(3'd2, 2'b00, 16'hABCD);
    check("pre_hold_a", a, 16'hABCD);
    hold = 1'b1; imm = 8'h77;
    wr(3'd2, 2'b00, 16'h0000);
    check("hold_a", a, 16'hABCD);
    check("hold_b", b, 16'h1234);
    check("hold_imm", imm_o, 16'h0005);
    hold = 1'b0;
    step();
    check("unhold_a", a, 16'h0000);
    check("unhold_imm", imm_o, 16'h0077);

    // Reserved write-back select suppresses write and bypass
    wr(3'd5, 2'b00, 16'h7777);
    ra = 3'd5; rb = 3'd5;
    we = 1'b1; wa = 3'd5; wb_sel = 2'b11;
    alu = 16'h1111; mdr = 16'h2222; link = 16'h3333;
    step();
    we = 1'b0;
    check("rsv_a", a, 16'h7777);
    check("rsv_b", b, 16'h7777);
    step();
    check("rsv_a_after", a, 16'h7777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_regfile_stage.md
Name: data_regfile_stage

Overview:
- Parametrised successor to the multi-cycle datapath's register-file/operand block.
- Holds a 2^ADDR_W x DATA_W register file with write-back source selection.
- Registers operands A/B and an extended immediate into pipeline-style output latches with hold control.
- Adds optional same-cycle write bypass, a hardwired zero register, and configurable immediate extension. Sits between decode and the ALU in the 16-bit multi-cycle processor.

Parameters:
- DATA_W, 16, datapath and register width
- ADDR_W, 3, register address width; NREGS = 2^ADDR_W
- IMM_IN_W, 8, width of the raw immediate field at input_imm[IMM_IN_W-1:0]
- BYPASS, 1, 1 = operand read of the register being written in the same cycle returns the new write data
- R0_ZERO, 1, 1 = register 0 always reads 0 and writes to it are discarded

Ports:
- CLK  input  1  system clock, rising-edge
- RST  input  1  asynchronous, active-high reset
- input_reg_readA_address  input  ADDR_W  operand A source register
- input_reg_readB_address  input  ADDR_W  operand B source register
- input_reg_write  input  1  write enable
- input_reg_write_address  input  ADDR_W  destination register
- wb_sel  input  2  write-back source: 00 ALUOut, 01 MDR, 10 input_link, 11 reserved (no write)
- input_ALUOut  input  DATA_W  ALU result
- input_MDR  input  DATA_W  memory data register
- input_link  input  DATA_W  return address for link writes
- input_imm  input  IMM_IN_W  raw immediate field
- imm_signed  input  1  1 = sign-extend, 0 = zero-extend
- input_branch  input  1  1 = shift extended immediate left by 1 (branch offset)
- hold  input  1  1 = output latches keep their value
- output_reg_A  output  DATA_W  registered operand A
- output_reg_B  output  DATA_W  registered operand B
- output_imm  output  DATA_W  registered extended immediate

Behaviour:
- Reset: on RST high, asynchronously clear all NREGS registers, output_reg_A, output_reg_B and output_imm to 0. Clock edges have no effect while RST is high.
- Write data mux: wdata = ALUOut / MDR / link per wb_sel. wb_sel = 11 suppresses the write even if input_reg_write = 1.
- Write: on the rising edge with input_reg_write = 1 and wb_sel != 11, store wdata to regs[write_address]. If R0_ZERO = 1 and the address is 0, the write is dropped.
- Operand read and latency:
  - On a rising edge with hold = 0, output_reg_A/B capture regs[readA/B_address] as seen that cycle.
  - Outputs are valid one cycle after the addresses are presented (1-cycle latency).
  - With hold = 1, all three outputs keep their value; register writes still occur.
- Bypass:
  - BYPASS = 1: if a valid write targets the same address as readA (or readB) on the same edge, the output captures wdata.
  - BYPASS = 0: the output captures the old contents, and the new value is visible from the next edge.
  - Both ports may bypass at once.
- Zero register: with R0_ZERO = 1, reads of address 0 always produce 0, including under bypass.
- Immediate:
  - ext = input_imm sign- or zero-extended from IMM_IN_W to DATA_W.
  - If input_branch = 1, ext is shifted left by 1; the MSB shifted out is discarded and bit 0 becomes 0.
  - output_imm captures ext on each edge with hold = 0.
- Simultaneous events:
  - A and B may address the same register.
  - Write and read of different registers in the same cycle are independent.
- Reset mid-operation: in-flight writes are lost; after RST falls, the first edge behaves as normal, with all registers reading 0.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: drive RST high with registers previously written -> all outputs 0 immediately. After release, reading r2/r3 gives A = 0000, B = 0000.
- Write then read: write r2 = ABCD (wb_sel 00), r3 = 5678 (wb_sel 01) on successive edges, then readA = 2, readB = 3 -> after the next edge A = ABCD, B = 5678.
- Bypass: write r4 = 1234 via link (wb_sel 10) with readA = 4 on the same edge.
  - BYPASS = 1 -> A = 1234 that edge.
  - BYPASS = 0 -> A = 0000, then A = 1234 on the following edge.
- Zero register: write r0 = FFFF, readA = 0, readB = 0 -> A = B = 0000 (R0_ZERO = 1).
- Immediate modes (IMM_IN_W = 8, imm = 0x9C):
  - signed -> FF9C.
  - unsigned -> 009C.
  - signed + branch -> FF38.
  - unsigned + branch -> 0138.
- Hold and reserved select:
  - A = ABCD with hold = 1 while writing r2 = 0000 -> A stays ABCD. After hold drops, A = 0000.
  - wb_sel = 11 with write = 1 to r5 -> r5 unchanged.
